// File: rtl/pair_packer_8_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pair_packer_8_pkg : tuple type, flat-array layout, pads, FSM states    |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package pair_packer_8_pkg;

   typedef struct packed {
      logic [15:0] hi;
      logic [15:0] lo;
   } tuple_pair_t;

   localparam int PAIR_W           = $bits(tuple_pair_t);
   localparam int ARR_8_N          = 8;
   localparam int ARR_8_FLAT_WIDTH = ARR_8_N * PAIR_W;

   // Pads chosen so that they land at the tail of the sort in either direction.
   localparam tuple_pair_t PAD_HI = '1;
   localparam tuple_pair_t PAD_LO = '0;

   typedef enum logic [0:0] {
      FILL = 1'b0,
      HOLD = 1'b1
   } packer_state_e;

   function automatic tuple_pair_t pad_for(input logic asc);
      return asc ? PAD_HI : PAD_LO;
   endfunction

   function automatic int index_flat(input int slot);
      return slot * PAIR_W;
   endfunction

endpackage
`default_nettype wire

// File: rtl/pair_packer_8_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pair_packer_8_if : pair stream in, packed group out to the sorter      |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
interface pair_packer_8_if;
   import pair_packer_8_pkg::*;

   logic                        pair_valid_in;
   tuple_pair_t                 pair_in;
   logic                        last_in;
   logic                        asc_cfg;
   logic                        ready_out;
   logic                        stall_in;
   logic                        valid_out;
   logic                        asc_out;
   logic [ARR_8_FLAT_WIDTH-1:0] pairs_out_flat;

   // master: feeder/sorter environment side
   modport master (
      output pair_valid_in, pair_in, last_in, asc_cfg, stall_in,
      input  ready_out, valid_out, asc_out, pairs_out_flat
   );

   // slave: the packer itself
   modport slave (
      input  pair_valid_in, pair_in, last_in, asc_cfg, stall_in,
      output ready_out, valid_out, asc_out, pairs_out_flat
   );
endinterface
`default_nettype wire

// File: rtl/pair_packer_8.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | pair_packer_8 : packs pairs into padded groups of 8 for the sorter     |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module pair_packer_8
   import pair_packer_8_pkg::*;
#(
   parameter bit ALT_DIR = 1'b0,
   parameter int CNT_W   = 16
) (
   input  logic             clock,
   input  logic             reset,
   pair_packer_8_if.slave   bus,
   output logic [CNT_W-1:0] group_cnt
);

   packer_state_e r_state;
   packer_state_e w_state_next;

   tuple_pair_t r_slots [ARR_8_N];
   tuple_pair_t r_out   [ARR_8_N];
   tuple_pair_t w_image [ARR_8_N];

   logic [3:0]                  r_cnt;
   logic                        r_toggle;
   logic                        r_hold_asc;
   logic                        r_hold_last;
   logic                        r_valid;
   logic                        r_asc;
   logic [CNT_W-1:0]            r_group_cnt;
   logic [ARR_8_FLAT_WIDTH-1:0] w_flat;

   logic       w_ready;
   logic       w_accept;
   logic       w_complete;
   logic       w_out_free;
   logic       w_xfer;
   logic       w_dir_now;
   logic       w_xfer_asc;
   logic       w_xfer_last;
   logic [3:0] w_xfer_cnt;

   assign w_accept   = bus.pair_valid_in && w_ready;
   assign w_complete = w_accept && ((r_cnt == 4'd7) || bus.last_in);
   assign w_out_free = !r_valid || !bus.stall_in;
   assign w_xfer     = ((r_state == FILL) && w_complete && w_out_free) ||
                       ((r_state == HOLD) && !bus.stall_in);

   assign w_dir_now   = ALT_DIR ? (bus.asc_cfg ^ r_toggle) : bus.asc_cfg;
   // A held group uses what was captured at completion; a direct transfer uses live values.
   assign w_xfer_asc  = (r_state == HOLD) ? r_hold_asc  : w_dir_now;
   assign w_xfer_last = (r_state == HOLD) ? r_hold_last : bus.last_in;
   assign w_xfer_cnt  = (r_state == HOLD) ? r_cnt       : r_cnt + 4'd1;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= FILL;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         FILL:    if (w_complete && !w_out_free) w_state_next = HOLD;
         HOLD:    if (!bus.stall_in)             w_state_next = FILL;
         default: w_state_next = FILL;
      endcase
   end

   always_comb begin
      w_ready = 1'b0;
      if (!reset && (r_state == FILL)) w_ready = 1'b1;
   end

   // Transfer image: the completing pair bypasses the slot array, tail slots get pads.
   always_comb begin
      for (int i = 0; i < ARR_8_N; i++) begin
         w_image[i] = r_slots[i];
         if (w_accept && (r_cnt == 4'(i))) w_image[i] = bus.pair_in;
         if (4'(i) >= w_xfer_cnt)          w_image[i] = pad_for(w_xfer_asc);
      end
   end

   always_ff @(posedge clock) begin
      if (w_accept) r_slots[r_cnt[2:0]] <= bus.pair_in;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt       <= 4'd0;
         r_toggle    <= 1'b0;
         r_hold_asc  <= 1'b1;
         r_hold_last <= 1'b0;
      end else begin
         if (w_xfer) begin
            r_cnt    <= 4'd0;
            r_toggle <= w_xfer_last ? 1'b0 : ~r_toggle;
         end else if (w_accept) begin
            r_cnt <= r_cnt + 4'd1;
         end
         if (w_complete) begin
            r_hold_asc  <= w_dir_now;
            r_hold_last <= bus.last_in;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_valid     <= 1'b0;
         r_asc       <= 1'b1;
         r_group_cnt <= '0;
         for (int i = 0; i < ARR_8_N; i++) r_out[i] <= PAD_LO;
      end else if (w_xfer) begin
         r_valid     <= 1'b1;
         r_asc       <= w_xfer_asc;
         r_group_cnt <= r_group_cnt + CNT_W'(1);
         for (int i = 0; i < ARR_8_N; i++) r_out[i] <= w_image[i];
      end else if (!bus.stall_in) begin
         r_valid <= 1'b0;
      end
   end

   always_comb begin
      w_flat = '0;
      for (int i = 0; i < ARR_8_N; i++) w_flat[index_flat(i) +: PAIR_W] = r_out[i];
   end

   assign bus.ready_out      = w_ready;
   assign bus.valid_out      = r_valid;
   assign bus.asc_out        = r_asc;
   assign bus.pairs_out_flat = w_flat;
   assign group_cnt          = r_group_cnt;

   a_hold_stable: assert property (@(posedge clock) disable iff (reset)
      (r_valid && bus.stall_in) |=> ($stable(w_flat) && $stable(r_asc)));

   a_no_accept_in_hold: assert property (@(posedge clock) disable iff (reset)
      (r_state == HOLD) |-> !w_accept);

endmodule
`default_nettype wire

// File: tb/tb_pair_packer_8.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_pair_packer_8 : vector table + scoreboard bench for pair_packer_8   |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_pair_packer_8;
   import pair_packer_8_pkg::*;

   localparam int W  = ARR_8_FLAT_WIDTH;
   localparam int PW = PAIR_W;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   pair_packer_8_if ifa ();
   pair_packer_8_if ifb ();
   logic [15:0] gcnt_a;
   logic [1:0]  gcnt_b;

   // Both DUTs see identical stimulus; B alternates direction and has a 2-bit counter.
   assign ifb.pair_valid_in = ifa.pair_valid_in;
   assign ifb.pair_in       = ifa.pair_in;
   assign ifb.last_in       = ifa.last_in;
   assign ifb.asc_cfg       = ifa.asc_cfg;
   assign ifb.stall_in      = ifa.stall_in;

   pair_packer_8 #(.ALT_DIR(1'b0), .CNT_W(16)) dut_a (
      .clock(clock), .reset(reset), .bus(ifa.slave), .group_cnt(gcnt_a));
   pair_packer_8 #(.ALT_DIR(1'b1), .CNT_W(2)) dut_b (
      .clock(clock), .reset(reset), .bus(ifb.slave), .group_cnt(gcnt_b));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic [W-1:0] flat;
      bit           asc;
      int           idx;
   } exp_t;

   tuple_pair_t cur[$];
   exp_t        qa[$], qb[$];
   exp_t        la, lb;
   bit          tog_b = 1'b0;
   int          idx   = 0;
   int          ga    = 0;

   function automatic logic [W-1:0] build(input bit asc);
      logic [W-1:0] f;
      for (int i = 0; i < 8; i++)
         f[i*PW +: PW] = (i < cur.size()) ? cur[i] : {PW{asc}};
      return f;
   endfunction

   task automatic model_accept(input tuple_pair_t p, input bit last);
      exp_t ea, eb;
      cur.push_back(p);
      if (cur.size() == 8 || last) begin
         idx++;
         ea.asc = ifa.asc_cfg;          ea.flat = build(ea.asc); ea.idx = idx;
         eb.asc = ifa.asc_cfg ^ tog_b;  eb.flat = build(eb.asc); eb.idx = idx;
         qa.push_back(ea);
         qb.push_back(eb);
         tog_b = last ? 1'b0 : ~tog_b;
         cur.delete();
      end
   endtask

   task automatic model_reset();
      cur.delete();
      qa.delete();
      qb.delete();
      tog_b = 1'b0;
      idx   = 0;
   endtask

   // Output monitor: a new group is any valid cycle not preceded by a stalled valid cycle.
   bit pv_a = 0, pv_b = 0, pstall = 0;
   always @(negedge clock) begin
      if (!reset) begin
         if (ifa.valid_out && !(pv_a && pstall)) begin
            if (qa.size() == 0) chk("A_spurious_group", W'(ifa.valid_out), W'(0));
            else begin
               la = qa.pop_front();
               ga++;
               chk("A_data", ifa.pairs_out_flat, la.flat);
               chk("A_asc", W'(ifa.asc_out), W'(la.asc));
               chk("A_group_cnt", W'(gcnt_a), W'(la.idx % 65536));
            end
         end else if (ifa.valid_out) begin
            chk("A_hold_data", ifa.pairs_out_flat, la.flat);
            chk("A_hold_asc", W'(ifa.asc_out), W'(la.asc));
         end
         if (ifb.valid_out && !(pv_b && pstall)) begin
            if (qb.size() == 0) chk("B_spurious_group", W'(ifb.valid_out), W'(0));
            else begin
               lb = qb.pop_front();
               chk("B_data", ifb.pairs_out_flat, lb.flat);
               chk("B_asc", W'(ifb.asc_out), W'(lb.asc));
               chk("B_group_cnt", W'(gcnt_b), W'(lb.idx % 4));
            end
         end else if (ifb.valid_out) begin
            chk("B_hold_data", ifb.pairs_out_flat, lb.flat);
         end
      end
      pv_a   = ifa.valid_out;
      pv_b   = ifb.valid_out;
      pstall = ifa.stall_in;
   end

   task automatic send(input tuple_pair_t p, input bit last);
      int guard = 0;
      ifa.pair_valid_in = 1'b1;
      ifa.pair_in       = p;
      ifa.last_in       = last;
      while (!ifa.ready_out && guard < 50) begin
         @(posedge clock); #1;
         guard++;
      end
      chk("ready_timeout", W'(ifa.ready_out), W'(1));
      chk("ready_match_b", W'(ifb.ready_out), W'(ifa.ready_out));
      model_accept(p, last);
      @(posedge clock); #1;
      ifa.pair_valid_in = 1'b0;
      ifa.last_in       = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while ((qa.size() + qb.size()) != 0 && g < 20) begin
         @(posedge clock); #1;
         g++;
      end
      chk("drain_timeout", W'(qa.size() + qb.size()), W'(0));
      repeat (2) @(posedge clock);
      #1;
   endtask

   typedef struct {
      int npairs;
      bit last_end;
      bit asc;
      int exp_groups;
   } vec_t;

   vec_t vec [7];

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g0;
      vec[0] = '{8,  1'b0, 1'b1, 1};
      vec[1] = '{3,  1'b1, 1'b1, 1};
      vec[2] = '{3,  1'b1, 1'b0, 1};
      vec[3] = '{8,  1'b1, 1'b1, 1};
      vec[4] = '{1,  1'b1, 1'b0, 1};
      vec[5] = '{24, 1'b1, 1'b1, 3};
      vec[6] = '{8,  1'b1, 1'b1, 1};

      ifa.pair_valid_in = 1'b0;
      ifa.pair_in       = '0;
      ifa.last_in       = 1'b0;
      ifa.asc_cfg       = 1'b0;
      ifa.stall_in      = 1'b0;

      repeat (2) @(posedge clock);
      #1;
      chk("rst_valid", W'(ifa.valid_out), W'(0));
      chk("rst_asc", W'(ifa.asc_out), W'(1));
      chk("rst_flat", ifa.pairs_out_flat, W'(0));
      chk("rst_gcnt", W'(gcnt_a), W'(0));
      chk("rst_ready", W'(ifa.ready_out), W'(0));
      chk("rst_asc_b", W'(ifb.asc_out), W'(1));
      reset = 1'b0;
      @(posedge clock); #1;
      chk("post_rst_ready", W'(ifa.ready_out), W'(1));

      for (int r = 0; r < 7; r++) begin
         ifa.asc_cfg = vec[r].asc;
         g0 = ga;
         for (int k = 0; k < vec[r].npairs; k++)
            send(tuple_pair_t'($urandom), vec[r].last_end && (k == vec[r].npairs - 1));
         drain();
         chk("row_groups", W'(ga - g0), W'(vec[r].exp_groups));
      end

      // Stall the first of two back-to-back groups until the second completes.
      ifa.asc_cfg = 1'b1;
      g0 = ga;
      for (int k = 0; k < 16; k++) begin
         send(tuple_pair_t'($urandom), 1'b0);
         if (k == 7) ifa.stall_in = 1'b1;
      end
      chk("hold_ready", W'(ifa.ready_out), W'(0));
      chk("hold_valid", W'(ifa.valid_out), W'(1));
      fork
         send(tuple_pair_t'($urandom), 1'b1);
         begin
            repeat (3) @(posedge clock);
            #1;
            chk("hold_ready_late", W'(ifa.ready_out), W'(0));
            ifa.stall_in = 1'b0;
         end
      join
      drain();
      chk("hold_groups", W'(ga - g0), W'(3));

      // Reset mid-assembly, then five fresh groups exercise the 2-bit counter wrap.
      for (int k = 0; k < 5; k++) send(tuple_pair_t'($urandom), 1'b0);
      reset = 1'b1;
      model_reset();
      @(posedge clock); #1;
      chk("midrst_ready", W'(ifa.ready_out), W'(0));
      chk("midrst_valid", W'(ifa.valid_out), W'(0));
      chk("midrst_gcnt_b", W'(gcnt_b), W'(0));
      @(posedge clock); #1;
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("postrst_no_valid", W'(ifa.valid_out), W'(0));
      g0 = ga;
      for (int k = 0; k < 40; k++) send(tuple_pair_t'($urandom), 1'b0);
      drain();
      chk("wrap_groups", W'(ga - g0), W'(5));
      chk("wrap_gcnt_a", W'(gcnt_a), W'(5));
      chk("wrap_gcnt_b", W'(gcnt_b), W'(1));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
